// File: rtl/eth_pkg.sv
// Shared types for the Ethernet transmit framer: queue word layout, FSM states, checksum helper.
package eth_pkg;

    typedef logic [33:0] eth_word_t;

    localparam int SOP_BIT = 32;
    localparam int EOP_BIT = 33;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        XMIT = 3'd1,
        CSUM = 3'd2,
        EOPW = 3'd3,
        GAP  = 3'd4
    } xmt_state_t;

    function automatic logic [31:0] csum_add(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/eth_xmt_fsm_if.sv
// Queue-side and port-side signals of the transmit framer; master = framer, slave = environment.
interface eth_xmt_fsm_if;
    import eth_pkg::*;

    logic        qEmpty;
    eth_word_t   qData;
    logic        qRdEn;
    logic        outReady;
    logic        outValid;
    logic [31:0] outData;
    logic        outSop;
    logic        outEop;

    modport master (
        input  qEmpty, qData, outReady,
        output qRdEn, outValid, outData, outSop, outEop
    );

    modport slave (
        output qEmpty, qData, outReady,
        input  qRdEn, outValid, outData, outSop, outEop
    );

endinterface

// File: rtl/eth_xmt_csum.sv
// Running 32-bit packet checksum: clear restarts the sum, and clear+add seeds it with the sop word.
module eth_xmt_csum
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        clear,
    input  logic        addEn,
    input  logic [31:0] addData,
    output logic [31:0] value
);

    logic [31:0] acc_r;

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            acc_r <= 32'd0;
        end else if (clear && addEn) begin
            acc_r <= addData;
        end else if (clear) begin
            acc_r <= 32'd0;
        end else if (addEn) begin
            acc_r <= csum_add(acc_r, addData);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign value = acc_r;

endmodule

// File: rtl/eth_xmt_fsm.sv
// Transmit framer: drains {eop,sop,data} queue words onto a valid/ready port with IPG and framing checks.
// Optional feature macro ETH_XMT_CSUM_EN appends a checksum word to every packet.
module eth_xmt_fsm
    import eth_pkg::*;
#(
    parameter int IPG_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetN,
    eth_xmt_fsm_if.master    bus,
    output logic             errFrame,
    output logic [CNT_W-1:0] pktCount
);

    localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
    localparam xmt_state_t AFTER_PKT = (IPG_CYCLES > 0) ? GAP : IDLE;

`ifdef ETH_XMT_CSUM_EN
    localparam xmt_state_t EOP_NEXT   = CSUM;
    localparam xmt_state_t ABORT_NEXT = CSUM;
`else
    localparam xmt_state_t EOP_NEXT   = EOPW;
    localparam xmt_state_t ABORT_NEXT = AFTER_PKT;
`endif

    xmt_state_t       state_r;
    logic [GAP_W-1:0] gapCnt_r;

    logic        transfer_s;
    logic        canLoad_s;
    logic        headSop_s;
    logic        headEop_s;
    logic        popReq_s;
    logic        loadQ_s;
    logic        drop_s;
    logic        abort_s;
    logic        csumLoad_s;
    logic        sendEop_s;
    logic [31:0] csumVal_s;

`ifdef ETH_XMT_CSUM_EN
    eth_xmt_csum u_csum (
        .clk     (clk),
        .resetN  (resetN),
        .clear   (loadQ_s && headSop_s),
        .addEn   (loadQ_s),
        .addData (bus.qData[31:0]),
        .value   (csumVal_s)
    );
    assign sendEop_s = 1'b0;
`else
    assign csumVal_s = 32'd0;
    assign sendEop_s = headEop_s;
`endif

    // Pop/load/error decisions for the current head word.
    always_comb begin
        transfer_s = bus.outValid && bus.outReady;
        canLoad_s  = !bus.outValid || bus.outReady;
        headSop_s  = bus.qData[SOP_BIT];
        headEop_s  = bus.qData[EOP_BIT];
        popReq_s   = resetN && !bus.qEmpty && canLoad_s;
        loadQ_s    = 1'b0;
        drop_s     = 1'b0;
        abort_s    = 1'b0;
        csumLoad_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (popReq_s) begin
                    loadQ_s = headSop_s;
                    drop_s  = !headSop_s;
                end else begin
                    loadQ_s = 1'b0;
                end
            end
            XMIT: begin
                // A new sop before any eop aborts the packet and stays in the queue.
                if (popReq_s) begin
                    loadQ_s = !headSop_s;
                    abort_s = headSop_s;
                end else begin
                    loadQ_s = 1'b0;
                end
            end
            CSUM: begin
                csumLoad_s = resetN && canLoad_s;
            end
            default: begin
                loadQ_s = 1'b0;
            end
        endcase
    end

    assign bus.qRdEn = loadQ_s || drop_s;

    // Output register, packet counter, error pulse and state machine.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            bus.outValid <= 1'b0;
            bus.outData  <= 32'd0;
            bus.outSop   <= 1'b0;
            bus.outEop   <= 1'b0;
            errFrame     <= 1'b0;
            pktCount     <= '0;
            state_r      <= IDLE;
            gapCnt_r     <= '0;
        end else begin
            errFrame <= drop_s || abort_s;

            if (loadQ_s) begin
                bus.outValid <= 1'b1;
                bus.outData  <= bus.qData[31:0];
                bus.outSop   <= headSop_s;
                bus.outEop   <= sendEop_s;
            end else if (csumLoad_s) begin
                bus.outValid <= 1'b1;
                bus.outData  <= csumVal_s;
                bus.outSop   <= 1'b0;
                bus.outEop   <= 1'b1;
            end else if (transfer_s) begin
                bus.outValid <= 1'b0;
            end else begin
                bus.outValid <= bus.outValid;
            end

            if (state_r == GAP) begin
                gapCnt_r <= gapCnt_r + GAP_W'(1);
            end else begin
                gapCnt_r <= '0;
            end

            case (state_r)
                IDLE: begin
                    if (loadQ_s) begin
                        state_r <= headEop_s ? EOP_NEXT : XMIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                XMIT: begin
                    if (loadQ_s && headEop_s) begin
                        state_r <= EOP_NEXT;
                    end else if (abort_s) begin
                        state_r <= ABORT_NEXT;
                    end else begin
                        state_r <= XMIT;
                    end
                end
                CSUM: begin
                    state_r <= csumLoad_s ? EOPW : CSUM;
                end
                EOPW: begin
                    // No new load happens here, so any transfer is the eop word itself.
                    if (transfer_s) begin
                        pktCount <= pktCount + CNT_W'(1);
                        state_r  <= AFTER_PKT;
                    end else begin
                        state_r <= EOPW;
                    end
                end
                GAP: begin
                    state_r <= (gapCnt_r == GAP_LAST) ? IDLE : GAP;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_xmt_fsm.sv
// Directed bench for eth_xmt_fsm: show-ahead queue model, port monitor, hand-computed expectations.
module tb_eth_xmt_fsm;
    import eth_pkg::*;

    localparam int IPG = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          resetN;
    logic          errFrame;
    logic [CW-1:0] pktCount;

    eth_xmt_fsm_if bus();

    eth_xmt_fsm #(.IPG_CYCLES(IPG), .CNT_W(CW)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .bus      (bus),
        .errFrame (errFrame),
        .pktCount (pktCount)
    );

    always #5 clk = ~clk;

    eth_word_t qMem [0:255];
    int        qHead = 0;
    int        qTail = 0;
    int        cyc   = 0;

    assign bus.qEmpty = (qHead == qTail);
    assign bus.qData  = qMem[qHead[7:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.qRdEn) qHead <= qHead + 1;
    end

    eth_word_t capW [$];
    int        capCyc [$];
    int        errCount = 0;

    always @(negedge clk) begin
        if (bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
            capW.push_back({bus.outEop, bus.outSop, bus.outData});
            capCyc.push_back(cyc);
        end
        if (errFrame === 1'b1) errCount++;
    end

    int nChecks = 0;
    int nBad    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic eth_word_t mk(input logic eop, input logic sop, input logic [31:0] d);
        return {eop, sop, d};
    endfunction

    task automatic push(input eth_word_t w);
        qMem[qTail[7:0]] = w;
        qTail = qTail + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    eth_word_t expW [$];

    task automatic checkPkt(input string tag, input int base);
        chk({tag, "_n"}, 64'(capW.size() - base), 64'(expW.size()));
        for (int i = 0; i < expW.size(); i++) begin
            if (base + i < capW.size())
                chk($sformatf("%s_w%0d", tag, i), 64'(capW[base + i]), 64'(expW[i]));
        end
        expW.delete();
    endtask

    int base;
    int eb;
    int k;
    int gap;
    int stride;
    int per;
    logic [CW-1:0] expCnt;

    initial begin
        resetN       = 1'b0;
        bus.outReady = 1'b1;
        expCnt       = '0;
        tick(3);
        chk("rst_out", {bus.outValid, bus.outSop, bus.outEop, bus.outData}, 64'd0);
        chk("rst_err", errFrame, 64'd0);
        chk("rst_cnt", pktCount, 64'd0);
        chk("rst_rden", bus.qRdEn, 64'd0);
        resetN = 1'b1;
        tick(2);

        // 1: 4-word packet, continuous ready
        base = capW.size(); eb = errCount;
        push(mk(1'b0, 1'b1, 32'h0000_ABCD)); push(mk(1'b0, 1'b0, 32'h0000_BEEF));
        push(mk(1'b0, 1'b0, 32'h0000_0001)); push(mk(1'b1, 1'b0, 32'h0000_0002));
        expW.push_back(mk(1'b0, 1'b1, 32'h0000_ABCD)); expW.push_back(mk(1'b0, 1'b0, 32'h0000_BEEF));
        expW.push_back(mk(1'b0, 1'b0, 32'h0000_0001));
`ifdef ETH_XMT_CSUM_EN
        expW.push_back(mk(1'b0, 1'b0, 32'h0000_0002)); expW.push_back(mk(1'b1, 1'b0, 32'h0001_6ABF));
`else
        expW.push_back(mk(1'b1, 1'b0, 32'h0000_0002));
`endif
        k = expW.size();
        tick(20);
        checkPkt("t1", base);
        for (int i = 1; i < k; i++) begin
            if (base + i < capCyc.size()) chk($sformatf("t1_cyc%0d", i), 64'(capCyc[base + i] - capCyc[base]), 64'(i));
        end
        expCnt = expCnt + 4'd1;
        chk("t1_cnt", pktCount, 64'(expCnt));
        chk("t1_err", 64'(errCount - eb), 64'd0);

        // 2: same packet, stalled three cycles with BEEF on the port
        base = capW.size();
        push(mk(1'b0, 1'b1, 32'h0000_ABCD)); push(mk(1'b0, 1'b0, 32'h0000_BEEF));
        push(mk(1'b0, 1'b0, 32'h0000_0001)); push(mk(1'b1, 1'b0, 32'h0000_0002));
        tick(2);
        bus.outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t2_hold%0d", i), {bus.outValid, bus.qRdEn, bus.outData}, {30'd0, 1'b1, 1'b0, 32'h0000_BEEF});
        end
        @(posedge clk); #1;
        bus.outReady = 1'b1;
        expW.push_back(mk(1'b0, 1'b1, 32'h0000_ABCD)); expW.push_back(mk(1'b0, 1'b0, 32'h0000_BEEF));
        expW.push_back(mk(1'b0, 1'b0, 32'h0000_0001));
`ifdef ETH_XMT_CSUM_EN
        expW.push_back(mk(1'b0, 1'b0, 32'h0000_0002)); expW.push_back(mk(1'b1, 1'b0, 32'h0001_6ABF));
`else
        expW.push_back(mk(1'b1, 1'b0, 32'h0000_0002));
`endif
        tick(20);
        checkPkt("t2", base);
        expCnt = expCnt + 4'd1;
        chk("t2_cnt", pktCount, 64'(expCnt));

        // 3: headless word in IDLE is dropped with a single error cycle
        base = capW.size(); eb = errCount;
        push(mk(1'b0, 1'b0, 32'h0000_0055));
        tick(10);
        chk("t3_err", 64'(errCount - eb), 64'd1);
        chk("t3_port", 64'(capW.size() - base), 64'd0);
        chk("t3_cnt", pktCount, 64'(expCnt));
        chk("t3_empty", bus.qEmpty, 64'd1);

        // 4: sop,data,sop aborts the first packet; second sop starts the next one after the gap
        base = capW.size(); eb = errCount;
        push(mk(1'b0, 1'b1, 32'h0000_0010)); push(mk(1'b0, 1'b0, 32'h0000_0011));
        push(mk(1'b0, 1'b1, 32'h0000_0020)); push(mk(1'b1, 1'b0, 32'h0000_0021));
        expW.push_back(mk(1'b0, 1'b1, 32'h0000_0010)); expW.push_back(mk(1'b0, 1'b0, 32'h0000_0011));
`ifdef ETH_XMT_CSUM_EN
        expW.push_back(mk(1'b1, 1'b0, 32'h0000_0021));
        k = 3;
        expW.push_back(mk(1'b0, 1'b1, 32'h0000_0020)); expW.push_back(mk(1'b0, 1'b0, 32'h0000_0021));
        expW.push_back(mk(1'b1, 1'b0, 32'h0000_0041));
        expCnt = expCnt + 4'd2;
`else
        k = 2;
        expW.push_back(mk(1'b0, 1'b1, 32'h0000_0020)); expW.push_back(mk(1'b1, 1'b0, 32'h0000_0021));
        expCnt = expCnt + 4'd1;
`endif
        tick(25);
        gap = (capCyc.size() > base + k) ? (capCyc[base + k] - capCyc[base + k - 1]) : -1;
        checkPkt("t4", base);
        chk("t4_gap", 64'(gap), 64'(IPG + 2));
        chk("t4_err", 64'(errCount - eb), 64'd1);
        chk("t4_cnt", pktCount, 64'(expCnt));

        // 5: three back-to-back single-word packets
        base = capW.size();
        for (int i = 0; i < 3; i++) begin
            push(mk(1'b1, 1'b1, 32'h0000_0007));
`ifdef ETH_XMT_CSUM_EN
            expW.push_back(mk(1'b0, 1'b1, 32'h0000_0007)); expW.push_back(mk(1'b1, 1'b0, 32'h0000_0007));
`else
            expW.push_back(mk(1'b1, 1'b1, 32'h0000_0007));
`endif
        end
`ifdef ETH_XMT_CSUM_EN
        stride = 2; per = IPG + 3;
`else
        stride = 1; per = IPG + 2;
`endif
        tick(30);
        for (int i = 1; i < 3; i++) begin
            gap = (capCyc.size() > base + i * stride) ? (capCyc[base + i * stride] - capCyc[base + (i - 1) * stride]) : -1;
            chk($sformatf("t5_gap%0d", i), 64'(gap), 64'(per));
        end
        checkPkt("t5", base);
        expCnt = expCnt + 4'd3;
        chk("t5_cnt", pktCount, 64'(expCnt));

        // 6: reset mid-packet; the leftover tail words are dropped as framing errors
        push(mk(1'b0, 1'b1, 32'h0000_0030)); push(mk(1'b0, 1'b0, 32'h0000_0031));
        push(mk(1'b0, 1'b0, 32'h0000_0032)); push(mk(1'b1, 1'b0, 32'h0000_0033));
        tick(2);
        resetN = 1'b0;
        tick(1);
        chk("t6_out", {bus.outValid, bus.outSop, bus.outEop, bus.outData}, 64'd0);
        chk("t6_cnt0", pktCount, 64'd0);
        chk("t6_rden", bus.qRdEn, 64'd0);
        resetN = 1'b1;
        base = capW.size(); eb = errCount;
        tick(10);
        chk("t6_err", 64'(errCount - eb), 64'd2);
        chk("t6_port", 64'(capW.size() - base), 64'd0);
        chk("t6_cnt", pktCount, 64'd0);
        chk("t6_empty", bus.qEmpty, 64'd1);

        // 7: counter wrap at 2^CW-1
        for (int i = 0; i < 15; i++) push(mk(1'b1, 1'b1, 32'(i)));
        tick(110);
        chk("t7_cnt15", pktCount, 64'd15);
        push(mk(1'b1, 1'b1, 32'h0000_00FF));
        tick(12);
        chk("t7_wrap", pktCount, 64'd0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
